zfsoc_pio_blink: RTL and testbench

Parametrised Avalon-MM output PIO for the ZFsoc LED and general-purpose output ports; the next generation of the fixed 6-bit LED PIO. It adds configurable width, atomic set, clear and toggle writes, and a hardware blink engine that flashes selected bits at a programmable half-period without CPU involvement. The block sits on the SoC Avalon fabric as a zero-wait-state slave and drives board pins directly.

---
 rtl/zfsoc_pio_pkg.sv | 15 +
 rtl/zfsoc_blink_timer.sv | 35 +++
 rtl/zfsoc_pio_blink.sv | 78 +++++++
 tb/tb_zfsoc_pio_blink.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/zfsoc_pio_pkg.sv
// Shared register map constants for the ZFsoc output PIO with blink engine.
package zfsoc_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE   = 3'd6;
  localparam logic [2:0] ADDR_RSVD     = 3'd7;

  localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/zfsoc_blink_timer.sv
// Half-period down-counter and phase flop driving the PIO blink mask.
module zfsoc_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;

  // A load of zero parks the engine immediately, even though the period
  // register itself only changes on this same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load) begin
      cnt   <= (load_val != '0) ? load_val - PERIOD_W'(1) : '0;
      phase <= 1'b0;
    end else if (period == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == '0) begin
      cnt   <= period - PERIOD_W'(1);
      phase <= ~phase;
    end else begin
      cnt   <= cnt - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/zfsoc_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear/toggle and a hardware blink engine.
module zfsoc_pio_blink
  import zfsoc_pio_pkg::*;
#(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PERIOD_W    = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    blink_en;
  logic [PERIOD_W-1:0] period;
  logic                phase;
  logic                wr;
  logic                period_load;
  logic [WIDTH-1:0]    wd_w;
  logic [PERIOD_W-1:0] wd_p;
  logic                unused_wd;

  assign wr          = chipselect & ~write_n;
  assign wd_w        = writedata[WIDTH-1:0];
  assign wd_p        = writedata[PERIOD_W-1:0];
  assign period_load = wr && (address == ADDR_PERIOD);
  assign unused_wd   = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data     <= RESET_VALUE;
      blink_en <= '0;
      period   <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:     data     <= wd_w;
        ADDR_BLINK_EN: blink_en <= wd_w;
        ADDR_PERIOD:   period   <= wd_p;
        ADDR_OUTSET:   data     <= data | wd_w;
        ADDR_OUTCLEAR: data     <= data & ~wd_w;
        ADDR_TOGGLE:   data     <= data ^ wd_w;
        default:       ;
      endcase
    end
  end

  zfsoc_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .period   (period),
    .load     (period_load),
    .load_val (wd_p),
    .phase    (phase)
  );

  // Blinking bits are forced low during the high phase; others follow DATA.
  assign out_port = data & ~(blink_en & {WIDTH{phase}});

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0]    = data;
      ADDR_BLINK_EN: readdata[WIDTH-1:0]    = blink_en;
      ADDR_PERIOD:   readdata[PERIOD_W-1:0] = period;
      ADDR_STATUS:   readdata[STATUS_PHASE_BIT] = phase;
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_zfsoc_pio_blink.sv
// Scoreboard bench for zfsoc_pio_blink: stimulus pushes expectations, a negedge monitor compares.
module tb_zfsoc_pio_blink;

  localparam int          W  = 6;
  localparam logic [W-1:0] RV = 6'h15;
  localparam int          PW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  zfsoc_pio_blink #(
    .WIDTH       (W),
    .RESET_VALUE (RV),
    .PERIOD_W    (PW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic [31:0]  rd;
    logic [2:0]   addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: architectural registers plus "edges since last nonzero PERIOD load".
  logic [W-1:0]  m_data;
  logic [W-1:0]  m_en;
  logic [PW-1:0] m_per;
  longint        m_k;

  bit            p_cs, p_wn;
  logic [2:0]    p_a;
  logic [31:0]   p_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic m_phase();
    if (m_per == '0) return 1'b0;
    return ((m_k / longint'(m_per)) % 2) == 1;
  endfunction

  function automatic logic [W-1:0] m_out();
    return m_data & ~(m_en & {W{m_phase()}});
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_data);
      3'd1: return 32'(m_en);
      3'd2: return 32'(m_per);
      3'd3: return {31'd0, m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_reset();
    m_data = RV; m_en = '0; m_per = '0; m_k = 0;
    p_cs = 0; p_wn = 1; p_a = 3'd0; p_wd = '0;
  endfunction

  function automatic void m_apply(input bit cs, input bit wn, input logic [2:0] a,
                                  input logic [31:0] wd);
    bit pw = 0;
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd[W-1:0];
        3'd1: m_en   = wd[W-1:0];
        3'd2: begin m_per = wd[PW-1:0]; m_k = 0; pw = 1; end
        3'd4: m_data = m_data | wd[W-1:0];
        3'd5: m_data = m_data & ~wd[W-1:0];
        3'd6: m_data = m_data ^ wd[W-1:0];
        default: ;
      endcase
    end
    if (!pw) m_k++;
  endfunction

  task automatic do_cycle(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] wd);
    exp_t e;
    @(posedge clk);
    m_apply(p_cs, p_wn, p_a, p_wd);
    #1;
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    p_cs = cs; p_wn = wn; p_a = a; p_wd = wd;
    e.out = m_out(); e.rd = m_rd(a); e.addr = a;
    q.push_back(e);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    do_cycle(1'b1, 1'b0, a, wd);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    do_cycle(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending", q.size());
      q.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("out_port", 32'(out_port), 32'(e.out));
        check($sformatf("readdata@%0d", e.addr), readdata, e.rd);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit            cs, wn;
    logic [2:0]    a;
    logic [31:0]   wd;
    int            r;

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    m_reset();
    #13;
    check("reset_out_port", 32'(out_port), 32'(RV));
    check("reset_readdata0", readdata, 32'(RV));
    #10 reset_n = 1'b1;

    rd_reg(3'd0); rd_reg(3'd1); rd_reg(3'd2); rd_reg(3'd3);

    wr_reg(3'd0, 32'hFFFF_FFC3); rd_reg(3'd0);
    wr_reg(3'd0, 32'h0000_000F);
    wr_reg(3'd4, 32'h30); rd_reg(3'd0);
    wr_reg(3'd5, 32'h05); rd_reg(3'd0);
    wr_reg(3'd6, 32'h3F); rd_reg(3'd0);
    rd_reg(3'd4); rd_reg(3'd5); rd_reg(3'd6); rd_reg(3'd7);
    wr_reg(3'd3, 32'hFFFF_FFFF); wr_reg(3'd7, 32'hFFFF_FFFF); rd_reg(3'd0);

    wr_reg(3'd0, 32'h3F); wr_reg(3'd1, 32'h01);
    wr_reg(3'd2, 32'd4);
    for (int i = 0; i < 9; i++) rd_reg(3'd3);
    wr_reg(3'd2, 32'd4);
    for (int i = 0; i < 5; i++) rd_reg(3'd3);
    wr_reg(3'd2, 32'd0);
    for (int i = 0; i < 100; i++) rd_reg(3'd3);
    wr_reg(3'd2, 32'd7); rd_reg(3'd3); rd_reg(3'd3);
    wr_reg(3'd2, 32'd3);
    for (int i = 0; i < 10; i++) rd_reg(3'd3);
    wr_reg(3'd2, 32'd1); wr_reg(3'd1, 32'h3F);
    for (int i = 0; i < 4; i++) rd_reg(3'd0);
    wr_reg(3'd6, 32'h2A); wr_reg(3'd4, 32'h01); wr_reg(3'd5, 32'h3C); rd_reg(3'd3);

    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99);
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      cs = (r >= 30) || (r < 5);
      wn = (r < 30) && !(r < 5) ? 1'b1 : (r >= 95);
      if (a == 3'd2 && $urandom_range(0, 19) != 0) wd = 32'($urandom_range(0, 9));
      do_cycle(cs, wn, a, wd);
    end

    wr_reg(3'd0, 32'h3F); wr_reg(3'd1, 32'h3F); wr_reg(3'd2, 32'd2);
    for (int i = 0; i < 5; i++) rd_reg(3'd3);
    drain();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    m_reset();
    chipselect = 1'b0; write_n = 1'b1;
    #1;
    check("async_out_port", 32'(out_port), 32'(RV));
    address = 3'd0; #1 check("async_rd_data", readdata, 32'(RV));
    address = 3'd1; #1 check("async_rd_en", readdata, 32'd0);
    address = 3'd2; #1 check("async_rd_period", readdata, 32'd0);
    address = 3'd3; #1 check("async_rd_status", readdata, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    wr_reg(3'd1, 32'h3F);
    for (int i = 0; i < 50; i++) rd_reg(3'd3);

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
